// File: rtl/shift_reg_pipe_if.sv
// Control/data bundle for shift_reg_pipe: the driver side is the master,
// the register itself is the slave.
interface shift_reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   shift_en;
    logic                   dir;
    logic                   rot;
    logic [WIDTH-1:0]       shift_in;
    logic                   load;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic [SEL_W-1:0]       tap_sel;
    logic [WIDTH-1:0]       shift_out;
    logic [WIDTH-1:0]       tap_out;
    logic [WIDTH*DEPTH-1:0] par_out;
    logic [CNT_W-1:0]       fill_cnt;
    logic                   full;
    logic                   empty;

    modport master (
        output shift_en, dir, rot, shift_in, load, load_data, tap_sel,
        input  shift_out, tap_out, par_out, fill_cnt, full, empty
    );

    modport slave (
        input  shift_en, dir, rot, shift_in, load, load_data, tap_sel,
        output shift_out, tap_out, par_out, fill_cnt, full, empty
    );
endinterface

// File: rtl/shift_reg_pipe.sv
// Bidirectional multi-lane shift register with rotate, parallel load,
// random-access tap and a saturating fill counter.
module shift_reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    shift_reg_pipe_if.slave  bus
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]       r_stage [DEPTH];
    logic [CNT_W-1:0]       r_fill;
    logic [WIDTH-1:0]       w_next  [DEPTH];
    logic [WIDTH-1:0]       w_shift_out;
    logic [WIDTH-1:0]       w_entry;
    logic [WIDTH-1:0]       w_tap;
    logic [WIDTH*DEPTH-1:0] w_par;

    // Exit stage depends on direction; in rotate mode it becomes the entry.
    assign w_shift_out = bus.dir ? r_stage[0] : r_stage[DEPTH-1];
    assign w_entry     = bus.rot ? w_shift_out : bus.shift_in;

    always_comb begin
        // NOTE: every element gets a default first so no path leaves it unassigned (no latch).
        for (int i = 0; i < DEPTH; i++) w_next[i] = '0;
        if (bus.dir) begin
            for (int i = 0; i < DEPTH - 1; i++) w_next[i] = r_stage[i+1];
            w_next[DEPTH-1] = w_entry;
        end else begin
            w_next[0] = w_entry;
            for (int i = 1; i < DEPTH; i++) w_next[i] = r_stage[i-1];
        end
    end

    // NOTE: the stage array is cleared on clr because the block promises all-zero outputs after reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge values of its neighbours.
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
            r_fill <= '0;
        end else if (bus.load) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= bus.load_data[i*WIDTH +: WIDTH];
            r_fill <= FULL_CNT;
        end else if (bus.shift_en) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= w_next[i];
            if (!bus.rot && (r_fill != FULL_CNT)) r_fill <= r_fill + CNT_W'(1);
        end
    end

    always_comb begin
        w_par = '0;
        for (int i = 0; i < DEPTH; i++) w_par[i*WIDTH +: WIDTH] = r_stage[i];
    end

    // Only non-power-of-two depths can select a missing stage.
    generate
        if ((1 << SEL_W) == DEPTH) begin : g_tap_full
            assign w_tap = r_stage[bus.tap_sel];
        end else begin : g_tap_part
            assign w_tap = (32'(bus.tap_sel) < DEPTH) ? r_stage[bus.tap_sel] : '0;
        end
    endgenerate

    assign bus.shift_out = w_shift_out;
    assign bus.tap_out   = w_tap;
    assign bus.par_out   = w_par;
    assign bus.fill_cnt  = r_fill;
    assign bus.full      = (r_fill == FULL_CNT);
    assign bus.empty     = (r_fill == '0);
endmodule

// File: tb/tb_shift_reg_pipe.sv
// Directed bench for shift_reg_pipe: a vector table for the fill/saturate
// path plus hand-written sequences for latency, rotate, direction flip and tap.
module tb_shift_reg_pipe;
    localparam int W   = 8;
    localparam int D   = 16;
    localparam int D12 = 12;

    typedef struct {
        string      name;
        logic       clr;
        logic       shift_en;
        logic       rot;
        logic [7:0] sin;
        logic [7:0] exp_out;
        logic [4:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    shift_reg_pipe_if #(.WIDTH(W), .DEPTH(D))   bus   ();
    shift_reg_pipe_if #(.WIDTH(W), .DEPTH(D12)) bus12 ();

    shift_reg_pipe #(.WIDTH(W), .DEPTH(D))   dut   (.clk(clk), .clr(clr), .bus(bus));
    shift_reg_pipe #(.WIDTH(W), .DEPTH(D12)) dut12 (.clk(clk), .clr(clr), .bus(bus12));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [4:0] exp_cnt);
        check(name, {bus.full, bus.empty, bus.fill_cnt},
              {(exp_cnt == 5'd16), (exp_cnt == 5'd0), exp_cnt});
    endtask

    vec_t             vecs [22];
    logic [127:0]     img;
    logic [127:0]     exp_par;
    logic [7:0]       hist [$];
    logic [7:0]       val;
    int               k;

    initial begin
        // ---- vector table: fill, saturate, hold, clr mid-stream, refill, rotate ----
        vecs[0] = '{"clr", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0};
        for (int i = 1; i <= 16; i++)
            vecs[i] = '{$sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, 8'(i),
                        (i == 16) ? 8'h01 : 8'h00, 5'(i)};
        vecs[17] = '{"sat17",  1'b0, 1'b1, 1'b0, 8'h11, 8'h02, 5'd16};
        vecs[18] = '{"hold",   1'b0, 1'b0, 1'b0, 8'h99, 8'h02, 5'd16};
        vecs[19] = '{"clr_mid",1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 5'd0};
        vecs[20] = '{"refill", 1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 5'd1};
        vecs[21] = '{"rot_cnt",1'b0, 1'b1, 1'b1, 8'h66, 8'h00, 5'd1};

        clr = 1'b1;
        bus.shift_en = 1'b0; bus.dir = 1'b0; bus.rot = 1'b0; bus.shift_in = '0;
        bus.load = 1'b0; bus.load_data = '0; bus.tap_sel = '0;
        bus12.shift_en = 1'b0; bus12.dir = 1'b0; bus12.rot = 1'b0; bus12.shift_in = '0;
        bus12.load = 1'b0; bus12.load_data = '0; bus12.tap_sel = '0;

        // ---- reset state ----
        tick();
        check("rst_shift_out", bus.shift_out, 0);
        check("rst_tap_out",   bus.tap_out, 0);
        check("rst_par_out",   bus.par_out, 0);
        check_cnt("rst_cnt", 5'd0);

        // ---- priority: clr beats load and shift ----
        clr = 1'b0; bus.load = 1'b1; bus.load_data = '1;
        tick();
        check("load_ones", bus.par_out, {128{1'b1}});
        clr = 1'b1; bus.shift_en = 1'b1;
        tick();
        check("prio_clr_par", bus.par_out, 0);
        check_cnt("prio_clr_cnt", 5'd0);
        bus.load = 1'b0; bus.shift_en = 1'b0;

        // ---- table-driven fill ----
        for (int i = 0; i < 22; i++) begin
            clr = vecs[i].clr; bus.shift_en = vecs[i].shift_en;
            bus.rot = vecs[i].rot; bus.shift_in = vecs[i].sin; bus.dir = 1'b0;
            tick();
            check({vecs[i].name, "_out"}, bus.shift_out, vecs[i].exp_out);
            check_cnt({vecs[i].name, "_cnt"}, vecs[i].exp_cnt);
        end
        clr = 1'b0; bus.shift_en = 1'b0; bus.rot = 1'b0;

        // ---- gapped latency: output equals input delayed by 16 enabled shifts ----
        clr = 1'b1; tick(); clr = 1'b0;
        k = 0;
        for (int s = 0; s < 40; s++) begin
            val = 8'($urandom_range(255));
            bus.shift_en = 1'b1; bus.shift_in = val;
            tick();
            hist.push_back(val);
            k++;
            check($sformatf("lat%0d", k), bus.shift_out, (k >= 16) ? hist[k-16] : 8'h00);
            bus.shift_en = 1'b0; bus.shift_in = 8'($urandom_range(255));
            for (int g = $urandom_range(3); g > 0; g--) begin
                tick();
                check($sformatf("lat_idle%0d", k), bus.shift_out, (k >= 16) ? hist[k-16] : 8'h00);
            end
        end

        // ---- fill 0x01..0x10 up, then tap sweep ----
        clr = 1'b1; tick(); clr = 1'b0;
        bus.dir = 1'b0; bus.rot = 1'b0; bus.shift_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.shift_in = 8'(i);
            tick();
        end
        bus.shift_en = 1'b0;
        for (int t = 0; t < 16; t++) begin
            bus.tap_sel = 4'(t);
            #1;
            check($sformatf("tap%0d", t), bus.tap_out, 8'(16 - t));
        end

        // ---- direction flip: one shift down with 0xAA entering stage 15 ----
        bus.dir = 1'b1; bus.shift_in = 8'hAA; bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        exp_par = '0;
        for (int i = 0; i < 15; i++) exp_par[i*8 +: 8] = 8'(15 - i);
        exp_par[15*8 +: 8] = 8'hAA;
        check("flip_par", bus.par_out, exp_par);
        check("flip_out", bus.shift_out, 8'h0F);
        check_cnt("flip_cnt", 5'd16);

        // ---- load beats shift, then 16 rotations down restore the image ----
        img = '0;
        for (int i = 0; i < 16; i++) img[i*8 +: 8] = 8'(i);
        bus.load = 1'b1; bus.load_data = img; bus.shift_en = 1'b1;
        bus.dir = 1'b1; bus.rot = 1'b1;
        tick();
        bus.load = 1'b0;
        check("load_noshift", bus.par_out, img);
        for (int s = 1; s <= 16; s++) begin
            tick();
            exp_par = '0;
            for (int i = 0; i < 16; i++) exp_par[i*8 +: 8] = 8'((i + s) % 16);
            check($sformatf("rot%0d_par", s), bus.par_out, exp_par);
            check_cnt($sformatf("rot%0d_cnt", s), 5'd16);
        end
        bus.shift_en = 1'b0; bus.rot = 1'b0;
        check("rot_restored", bus.par_out, img);

        // ---- DEPTH=12: taps past the last stage read zero ----
        bus12.load = 1'b1; bus12.load_data = '1;
        tick();
        bus12.load = 1'b0;
        bus12.tap_sel = 4'd13; #1;
        check("d12_tap13", bus12.tap_out, 8'h00);
        bus12.tap_sel = 4'd12; #1;
        check("d12_tap12", bus12.tap_out, 8'h00);
        bus12.tap_sel = 4'd11; #1;
        check("d12_tap11", bus12.tap_out, 8'hFF);
        check("d12_cnt", {bus12.full, bus12.fill_cnt}, {1'b1, 4'd12});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
